vedic_mul_seq: RTL

//  Multicycle, parametrised WIDTHxWIDTH multiplier for the RISC-V M-extension datapath.
//  One half-width Vedic core is time-shared over four partial products (LL, LH, HL, HH).

---
 rtl/vedic_mul_seq_pkg.sv | 21 ++
 rtl/vedic_mul_seq_if.sv | 23 ++
 rtl/vedic_mul_unsigned_nbits.sv | 26 ++
 rtl/vedic_mul_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vedic_mul_seq_pkg.sv
// Shared types for the sequential Vedic multiplier: RISC-V M-extension op encoding and FSM states.
package vedic_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PP0  = 3'd1,
        S_PP1  = 3'd2,
        S_PP2  = 3'd3,
        S_PP3  = 3'd4,
        S_CORR = 3'd5,
        S_DONE = 3'd6
    } mul_state_e;

endpackage

// File: rtl/vedic_mul_seq_if.sv
// Issue-side and writeback-side valid/ready handshake of the sequential multiplier.
interface vedic_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/vedic_mul_unsigned_nbits.sv
// Combinational unsigned WIDTHxWIDTH -> 2*WIDTH Vedic (urdhva) multiplier, built recursively
// from four half-width cores; odd or small widths fall back to a plain product.
module vedic_mul_unsigned_nbits #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    if (WIDTH <= 4 || (WIDTH % 2) != 0) begin : g_leaf
        assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end else begin : g_split
        localparam int Q = WIDTH / 2;
        logic [WIDTH-1:0] ll, lh, hl, hh;

        vedic_mul_unsigned_nbits #(.WIDTH(Q)) u_ll (.a(a[Q-1:0]),     .b(b[Q-1:0]),     .p(ll));
        vedic_mul_unsigned_nbits #(.WIDTH(Q)) u_lh (.a(a[Q-1:0]),     .b(b[WIDTH-1:Q]), .p(lh));
        vedic_mul_unsigned_nbits #(.WIDTH(Q)) u_hl (.a(a[WIDTH-1:Q]), .b(b[Q-1:0]),     .p(hl));
        vedic_mul_unsigned_nbits #(.WIDTH(Q)) u_hh (.a(a[WIDTH-1:Q]), .b(b[WIDTH-1:Q]), .p(hh));

        // Cross terms land Q bits up; hh/ll concatenate without overlap.
        assign p = {hh, ll}
                 + ({{WIDTH{1'b0}}, lh} << Q)
                 + ({{WIDTH{1'b0}}, hl} << Q);
    end
endmodule

// File: rtl/vedic_mul_seq.sv
// Multicycle WIDTHxWIDTH multiplier (MUL/MULH/MULHSU/MULHU) time-sharing one half-width Vedic core.
// Optional last-operand cache: define VEDIC_MUL_SEQ_OPCACHE_EN.
module vedic_mul_seq
    import vedic_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    vedic_mul_seq_if.slave   bus,
    output logic             busy
);
    localparam int H  = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;

    mul_state_e        state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    mul_op_e           op_q;
    logic [W2-1:0]     acc;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_result_q;

    logic [H-1:0]      core_a, core_b;
    logic [WIDTH-1:0]  core_p;
    logic [W2-1:0]     pp_shifted;
    logic [W2-1:0]     acc_sum;
    logic [WIDTH-1:0]  corr_hi;
    logic [WIDTH-1:0]  res_sel;
    logic              a_signed, b_signed;
    logic              cache_hit;

    vedic_mul_unsigned_nbits #(.WIDTH(H)) u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    assign acc_sum  = acc + pp_shifted;
    assign a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    assign b_signed = (op_q == OP_MULH);
    // Unsigned product minus the weight of each negative signed operand, on the high half only.
    assign corr_hi  = acc[W2-1:WIDTH]
                    - ((a_signed && a_q[WIDTH-1]) ? b_q : '0)
                    - ((b_signed && b_q[WIDTH-1]) ? a_q : '0);
    assign res_sel  = (op_q == OP_MUL) ? acc[WIDTH-1:0] : acc[W2-1:WIDTH];

`ifdef VEDIC_MUL_SEQ_OPCACHE_EN
    logic [WIDTH-1:0] last_a, last_b;
    logic [W2-1:0]    last_acc;
    logic             last_vld;

    // Compared against the latched operands in PP0, keeping the comparator off the input path.
    assign cache_hit = last_vld && (a_q == last_a) && (b_q == last_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_a   <= '0;
            last_b   <= '0;
            last_acc <= '0;
            last_vld <= 1'b0;
        end else if (flush) begin
            last_vld <= 1'b0;
        end else if (state_q == S_PP3) begin
            last_a   <= a_q;
            last_b   <= b_q;
            last_acc <= acc_sum;
            last_vld <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.in_valid) state_d = S_PP0;
                S_PP0:   state_d = cache_hit ? S_CORR : S_PP1;
                S_PP1:   state_d = S_PP2;
                S_PP2:   state_d = S_PP3;
                S_PP3:   state_d = S_CORR;
                S_CORR:  state_d = S_DONE;
                S_DONE:  if (out_valid_q && bus.out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = (state_q == S_IDLE);
        busy         = (state_q != S_IDLE);
        core_a       = a_q[H-1:0];
        core_b       = b_q[H-1:0];
        pp_shifted   = {{WIDTH{1'b0}}, core_p};
        case (state_q)
            S_PP1: begin
                core_b     = b_q[WIDTH-1:H];
                pp_shifted = {{WIDTH{1'b0}}, core_p} << H;
            end
            S_PP2: begin
                core_a     = a_q[WIDTH-1:H];
                pp_shifted = {{WIDTH{1'b0}}, core_p} << H;
            end
            S_PP3: begin
                core_a     = a_q[WIDTH-1:H];
                core_b     = b_q[WIDTH-1:H];
                pp_shifted = {core_p, {WIDTH{1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_MUL;
            acc          <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    a_q  <= bus.in_a;
                    b_q  <= bus.in_b;
                    op_q <= mul_op_e'(bus.in_op);
                    acc  <= '0;
                end
`ifdef VEDIC_MUL_SEQ_OPCACHE_EN
                S_PP0:  acc <= cache_hit ? last_acc : acc_sum;
`else
                S_PP0:  acc <= acc_sum;
`endif
                S_PP1, S_PP2, S_PP3: acc <= acc_sum;
                S_CORR: acc[W2-1:WIDTH] <= corr_hi;
                // First DONE cycle registers the result; it then holds until the consumer takes it.
                S_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q  <= 1'b1;
                        out_result_q <= res_sel;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;

endmodule
